binary_mul_seq_param: RTL and testbench

//  Parametrised iterative shift-add multiplier; next generation of the fixed 14-bit unsigned

---
 rtl/binary_mul_seq_param.sv | 130 +++++++++++++
 tb/tb_binary_mul_seq_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/binary_mul_seq_param.sv
// Iterative shift-add multiplier, STEP multiplier bits retired per CALC cycle, valid/ready on both sides.
// Define BINARY_MUL_SIGNED_EN to add the sgn port and two's-complement operation.
module binary_mul_seq_param #(
    parameter int WIDTH = 14,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef BINARY_MUL_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising clk edge with en=1 when valid and
    // ready are both high on that side; valid must be held until that edge.
    localparam int ITER = (WIDTH + STEP - 1) / STEP;
    localparam int BW   = ITER * STEP;
    localparam int CW   = $clog2(ITER + 1);
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [BW-1:0]    b_reg;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg_reg;

    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic             neg_op;
    logic [PW-1:0]    pp;
    logic             accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = en && in_valid && in_ready;
    assign dbg_state = state;

    // Signed mode multiplies magnitudes; the most negative value fits as unsigned.
    always_comb begin
        a_op   = A;
        b_op   = B;
        neg_op = 1'b0;
`ifdef BINARY_MUL_SIGNED_EN
        if (sgn) begin
            if (A[WIDTH-1]) a_op = -A;
            if (B[WIDTH-1]) b_op = -B;
            neg_op = A[WIDTH-1] ^ B[WIDTH-1];
        end
`endif
    end

    always_comb begin
        pp = PW'(a_reg) * PW'(b_reg[STEP-1:0]);
        pp = pp << (int'(cnt) * STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_reg   <= 1'b0;
            P         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a_op;
                        b_reg   <= BW'(b_op);
                        neg_reg <= neg_op;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == CW'(ITER)) begin
                        P         <= neg_reg ? -acc : acc;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        acc   <= acc + pp;
                        b_reg <= b_reg >> STEP;
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_reg   <= a_op;
                            b_reg   <= BW'(b_op);
                            neg_reg <= neg_op;
                            acc     <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_mul_seq_param.sv
// Directed bench for binary_mul_seq_param: WIDTH=14 with STEP=1 and STEP=4 instances.
module tb_binary_mul_seq_param;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid, out_ready, sgn;
    logic [13:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [27:0] p;
    logic [1:0]  dbg_state;

    logic        in_valid4, out_ready4;
    logic [13:0] a4, b4;
    logic        in_ready4, out_valid4, busy4;
    logic [27:0] p4;
    logic [1:0]  dbg_state4;

    int          checks = 0;
    int          errors = 0;
    logic [27:0] exp_q[$];

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [27:0] p;
        string       name;
    } vec_t;
    vec_t vecs[8];

    binary_mul_seq_param #(.WIDTH(14), .STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b),
`ifdef BINARY_MUL_SIGNED_EN
        .sgn(sgn),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .P(p), .busy(busy),
        .dbg_state(dbg_state)
    );

    binary_mul_seq_param #(.WIDTH(14), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4),
`ifdef BINARY_MUL_SIGNED_EN
        .sgn(1'b0),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .P(p4), .busy(busy4),
        .dbg_state(dbg_state4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, scramble the inputs, measure latency, then retire.
    task automatic run_op(input logic [13:0] av, input logic [13:0] bv, input logic [27:0] pv,
                          input string name);
        int n;
        exp_q.push_back(pv);
        check({name, "_in_ready"}, in_ready, 1);
        a = av; b = bv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 14'($urandom_range(0, 16383));
        b = 14'($urandom_range(0, 16383));
        check({name, "_busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check({name, "_latency"}, n, 15);
        check({name, "_p"}, p, exp_q.pop_front());
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_retired"}, out_valid, 0);
        check({name, "_p_kept"}, p, pv);
    endtask

    task automatic run_op4(input logic [13:0] av, input logic [13:0] bv, input logic [27:0] pv,
                           input string name);
        int n;
        a4 = av; b4 = bv; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 100) begin
            step();
            n++;
        end
        check({name, "_latency"}, n, 5);
        check({name, "_p"}, p4, pv);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check({name, "_retired"}, out_valid4, 0);
    endtask

    initial begin
        int  n;
        logic seen;

        vecs[0] = '{14'd16383, 14'd16383, 28'd268402689, "max_max"};
        vecs[1] = '{14'd0,     14'd9999,  28'd0,         "zero_a"};
        vecs[2] = '{14'd9999,  14'd0,     28'd0,         "zero_b"};
        vecs[3] = '{14'd1,     14'd1,     28'd1,         "one_one"};
        vecs[4] = '{14'd16383, 14'd1,     28'd16383,     "max_one"};
        vecs[5] = '{14'd8192,  14'd2,     28'd16384,     "msb_two"};
        vecs[6] = '{14'd12345, 14'd2,     28'd24690,     "mid_two"};
        vecs[7] = '{14'd1234,  14'd4321,  28'd5332114,   "mid_mid"};

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sgn = 1'b0;
        a = '0; b = '0; in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;

        // reset state
        #12;
        check("rst_p", p, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);

        // back-to-back with both handshakes tied high
        a = 14'd3; b = 14'd5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        check("b2b_lat0", n, 15);
        check("b2b_p0", p, 15);
        a = 14'd100; b = 14'd200;
        step();
        check("b2b_retire0", out_valid, 0);
        check("b2b_busy", busy, 1);
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        check("b2b_lat1", n, 15);
        check("b2b_p1", p, 20000);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("b2b_idle", dbg_state, 0);
        check("b2b_p_kept", p, 20000);

        // clock-enable stall mid-CALC, then hold in DONE
        a = 14'd1234; b = 14'd4321; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (n == 5) en = 1'b0;
            if (n == 12) en = 1'b1;
            step();
            n++;
        end
        check("stall_latency", n, 22);
        check("stall_p", p, 5332114);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_p", p, 5332114);
        end
        en = 1'b0; out_ready = 1'b1;
        step();
        check("en_low_hold", out_valid, 1);
        en = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall_retired", out_valid, 0);

        // reset in the middle of CALC discards the operation
        a = 14'd1111; b = 14'd2222; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_p", p, 0);
        repeat (2) step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", seen, 0);
        run_op(14'd7, 14'd9, 28'd63, "after_rst");

        // STEP=4 instance
        run_op4(14'd16383, 14'd1, 28'd16383, "s4_max_one");
        run_op4(14'd12345, 14'd6789, 28'd83810205, "s4_mid");
        run_op4(14'd16383, 14'd16383, 28'd268402689, "s4_max_max");

`ifdef BINARY_MUL_SIGNED_EN
        sgn = 1'b1;
        run_op(14'h2000, 14'h3FFF, 28'd8192, "sg_min_m1");
        run_op(14'h2000, 14'd8191, 28'd201334784, "sg_min_max");
        run_op(14'd3, 14'h3FFB, 28'd268435441, "sg_3_m5");
        sgn = 1'b0;
        run_op(14'h2000, 14'h3FFF, 28'd134209536, "us_hi_bits");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
